// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - parallel-in, MSB-first serial-out sequencer with per-bit hold
module shift_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   output logic             ser_out,
   output logic             ser_en,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [DW-1:0]    div_cnt;

   // Gated by rst so a word offered during reset is never seen as accepted.
   assign in_ready = (state == S_IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         ser_out <= 1'b0;
         ser_en  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (in_valid) begin
                  state   <= S_SHIFT;
                  shreg   <= in_data;
                  bit_cnt <= '0;
                  div_cnt <= '0;
                  ser_out <= in_data[WIDTH-1];
                  ser_en  <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            S_SHIFT: begin
               if (abort) begin
                  state   <= S_IDLE;
                  shreg   <= '0;
                  bit_cnt <= '0;
                  div_cnt <= '0;
                  ser_out <= 1'b0;
                  ser_en  <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     state   <= S_DONE;
                     shreg   <= '0;
                     bit_cnt <= '0;
                     ser_out <= 1'b0;
                     ser_en  <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     // Rotating keeps every stored bit live; the MSB slot is never observed again.
                     shreg   <= {shreg[WIDTH-2:0], shreg[WIDTH-1]};
                     bit_cnt <= bit_cnt + 1'b1;
                     ser_out <= shreg[WIDTH-2];
                     ser_en  <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
                  ser_en  <= 1'b0;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end

            default: begin
               state   <= S_IDLE;
               shreg   <= '0;
               bit_cnt <= '0;
               div_cnt <= '0;
               ser_out <= 1'b0;
               ser_en  <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
